pipelined_adder: RTL and testbench
==================================

// Module: pipelined_adder
// PURPOSE
//   Parametrised, pipelined add/subtract unit; next generation of the 32-bit combinational adder.
//   Splits a WIDTH-bit operation into STAGES carry-linked segments, one segment per clock.
//   Uses valid/ready handshakes on both sides, so it can sit between streaming datapath blocks
//   and sustain one operation per cycle at high clock rates.
// PARAMETERS
//   WIDTH   32  operand width in bits; must be a multiple of STAGES
//   STAGES  4   pipeline depth, i.e. the number of segments; SEG = WIDTH/STAGES bits per segment; legal range 1..WIDTH
// PORTS
//   clk        in   1        rising-edge clock
//   rst        in   1        synchronous, active-high reset
//   in_valid   in   1        a, b and sub are valid this cycle
//   in_ready   out  1        block accepts the input this cycle
//   a          in   WIDTH    operand A, unsigned or two's complement
//   b          in   WIDTH    operand B
//   sub        in   1        0: a+b; 1: a-b
//   out_valid  out  1        sum, overflow and sub_o are valid
//   out_ready  in   1        downstream accepts the result this cycle
//   sum        out  WIDTH+1  result; sum[WIDTH] is the unsigned carry (add) or borrow (sub)
//   overflow   out  1        signed two's-complement overflow of sum[WIDTH-1:0]
//   sub_o      out  1        the sub flag travelling with this result
// BEHAVIOUR
//   - Reset: while rst=1 at a clk edge, every stage valid bit and every output clears to 0.
//     This covers out_valid, sum, overflow and sub_o.
//     A reset mid-operation discards all in-flight operations; nothing is emitted for them.
//   - Handshake: adv = !out_valid | out_ready.
//     in_ready = adv, combinational; during rst, in_ready = 0.
//     A transfer happens when in_valid & in_ready.
//     When adv=1, every stage shifts forward one position on the edge; when adv=0, all stages hold.
//     The stall is global: there are no bubbles-collapse rules.
//     A bubble enters stage 0 when adv=1 and in_valid=0.
//     out_valid and sum stay stable while out_valid=1 and out_ready=0.
//   - Latency: exactly STAGES cycles from the accepting edge to out_valid=1, with no stall.
//     Throughput is 1 op/cycle when out_ready is held at 1.
//   - Arithmetic: the effective B is bx = sub ? ~b : b, and the carry-in is cin = sub.
//     Stage k adds a[k*SEG +: SEG] + bx[k*SEG +: SEG] + carry from stage k-1.
//     Stage 0 uses cin as its carry.
//     Upper unprocessed operand bits and lower finished sum bits are registered alongside each stage.
//     Final carry c = carry out of the top segment.
//     sum[WIDTH] = sub ? ~c : c, so the borrow reads 1 exactly when unsigned a < b.
//     overflow = (a[W-1] == bx[W-1]) & (sum[W-1] != a[W-1]), using the original a and the effective bx MSBs.
//     The result equals a combinational a+b, or a-b, for every input.
//   - STAGES=1 degenerates to a single registered adder with latency 1.
//   - Boundaries:
//     - all-ones + 1 wraps to 0 with carry 1.
//     - 0 - 1 gives all-ones with borrow 1.
//     - Simultaneous in-transfer and out-transfer in the same cycle with the pipe full is legal; no loss.
//     - Back-pressure of any length loses and duplicates nothing.
// TESTING
//   1. rst=1 for 2 cycles with in_valid=1 -> out_valid=0 and sum=0, and no output appears after rst falls.
//   2. WIDTH=32, STAGES=4; a=0xFFFF_FFFF, b=1, sub=0 -> after 4 cycles, sum=0x1_0000_0000 and overflow=0.
//   3. a=0, b=1, sub=1 -> sum=0x1_FFFF_FFFF (borrow=1), overflow=0.
//      Then a=0x8000_0000, b=1, sub=1 -> sum=0x0_7FFF_FFFF, overflow=1.
//   4. Streaming: issue 16 back-to-back ops with out_ready=1 -> 16 results on consecutive cycles, in order.
//      The first result arrives at cycle 4.
//   5. Back-pressure: out_ready toggled randomly while in_valid=1 on 1000 random ops.
//      -> in_ready=0 whenever out_valid & !out_ready; the result stream matches the reference model exactly.
//   6. Assert rst while 3 ops are in flight -> none of those ops is ever output.
//      A new op issued after reset returns correctly after 4 cycles.

Source files
------------

// File: rtl/pipelined_adder.sv
// pipelined_adder
//   Pipelined add/subtract unit. A WIDTH-bit operation is split into STAGES
//   carry-linked segments of SEG = WIDTH/STAGES bits; stage k adds segment k
//   and passes its carry to stage k+1 on the next clock. Valid/ready
//   handshakes on both sides; the whole pipe advances or stalls as one.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset; flushes all in-flight ops
//   in_valid   in   a, b, sub valid this cycle
//   in_ready   out  input accepted this cycle (0 during rst)
//   a, b       in   WIDTH-bit operands
//   sub        in   0: a+b, 1: a-b
//   out_valid  out  sum, overflow, sub_o valid
//   out_ready  in   downstream accepts the result this cycle
//   sum        out  WIDTH+1 result; sum[WIDTH] = carry (add) or borrow (sub)
//   overflow   out  signed overflow of sum[WIDTH-1:0]
//   sub_o      out  sub flag travelling with the result
module pipelined_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic             overflow,
  output logic             sub_o
);

  localparam int SEG  = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  // Per-stage registers. a_q keeps the original operand and bx_q the
  // effective (possibly inverted) B so the top stage can form overflow from
  // the original MSBs; s_q holds the finished low segments.
  logic             valid_q [STAGES];
  logic             valid_d [STAGES];
  logic             sub_q   [STAGES];
  logic             sub_d   [STAGES];
  logic             carry_q [STAGES];
  logic             carry_d [STAGES];
  logic [WIDTH-1:0] a_q     [STAGES];
  logic [WIDTH-1:0] a_d     [STAGES];
  logic [WIDTH-1:0] bx_q    [STAGES];
  logic [WIDTH-1:0] bx_d    [STAGES];
  logic [WIDTH-1:0] s_q     [STAGES];
  logic [WIDTH-1:0] s_d     [STAGES];
  logic             ovf_q;
  logic             ovf_d;

  // What each stage sees as its input: stage 0 from the ports, others from
  // the previous stage's registers.
  logic             vin_s   [STAGES];
  logic             subin_s [STAGES];
  logic             cin_s   [STAGES];
  logic [WIDTH-1:0] ain_s   [STAGES];
  logic [WIDTH-1:0] bxin_s  [STAGES];
  logic [WIDTH-1:0] psum_s  [STAGES];
  logic [SEG:0]     seg_s   [STAGES];
  logic             adv_s;

  function automatic logic [SEG:0] seg_add_f(input logic [SEG-1:0] x,
                                             input logic [SEG-1:0] y,
                                             input logic           ci);
    return {1'b0, x} + {1'b0, y} + {{SEG{1'b0}}, ci};
  endfunction

  function automatic logic ovf_f(input logic a_msb, input logic bx_msb,
                                 input logic s_msb);
    return (a_msb == bx_msb) && (s_msb != a_msb);
  endfunction

  // Global advance: the pipe moves whenever the output slot is free or drained.
  assign adv_s     = !valid_q[LAST] || out_ready;
  assign in_ready  = adv_s && !rst;
  assign out_valid = valid_q[LAST];
  assign sum       = {carry_q[LAST], s_q[LAST]};
  assign overflow  = ovf_q;
  assign sub_o     = sub_q[LAST];

  // Route port inputs into stage 0 and each stage's registers into the next.
  always_comb begin
    vin_s[0]   = in_valid;
    subin_s[0] = sub;
    ain_s[0]   = a;
    bxin_s[0]  = sub ? ~b : b;
    psum_s[0]  = {WIDTH{1'b0}};
    cin_s[0]   = sub;
    for (int k = 1; k < STAGES; k++) begin
      vin_s[k]   = valid_q[k-1];
      subin_s[k] = sub_q[k-1];
      ain_s[k]   = a_q[k-1];
      bxin_s[k]  = bx_q[k-1];
      psum_s[k]  = s_q[k-1];
      cin_s[k]   = carry_q[k-1];
    end
  end

  // Segment adders and next-state for every stage; the top stage also folds
  // the carry into a borrow for subtraction and computes overflow.
  always_comb begin
    ovf_d = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      seg_s[k]   = seg_add_f(ain_s[k][k*SEG +: SEG], bxin_s[k][k*SEG +: SEG], cin_s[k]);
      valid_d[k] = vin_s[k];
      sub_d[k]   = subin_s[k];
      a_d[k]     = ain_s[k];
      bx_d[k]    = bxin_s[k];
      s_d[k]     = psum_s[k];
      s_d[k][k*SEG +: SEG] = seg_s[k][SEG-1:0];
      if (k == LAST) begin
        // a-b = a + ~b + 1 carries out exactly when no borrow occurred.
        carry_d[k] = seg_s[k][SEG] ^ subin_s[k];
        ovf_d      = ovf_f(ain_s[k][WIDTH-1], bxin_s[k][WIDTH-1], s_d[k][WIDTH-1]);
      end else begin
        carry_d[k] = seg_s[k][SEG];
      end
    end
  end

  // Pipeline registers: clear on reset, shift together on advance, else hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= 1'b0;
        sub_q[k]   <= 1'b0;
        carry_q[k] <= 1'b0;
        a_q[k]     <= {WIDTH{1'b0}};
        bx_q[k]    <= {WIDTH{1'b0}};
        s_q[k]     <= {WIDTH{1'b0}};
      end
      ovf_q <= 1'b0;
    end else if (adv_s) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= valid_d[k];
        sub_q[k]   <= sub_d[k];
        carry_q[k] <= carry_d[k];
        a_q[k]     <= a_d[k];
        bx_q[k]    <= bx_d[k];
        s_q[k]     <= s_d[k];
      end
      ovf_q <= ovf_d;
    end
  end

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder (WIDTH=32, STAGES=4).
// Expected results come from plain integer arithmetic on each accepted op,
// kept in a FIFO and compared against every emitted result.
module tb_pipelined_adder;

  localparam int W = 32;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W:0]   sum;
  logic         overflow;
  logic         sub_o;

  always #5 clk = ~clk;

  pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .overflow(overflow), .sub_o(sub_o)
  );

  typedef struct packed {
    logic [W:0] s;
    logic       o;
    logic       sb;
  } exp_t;

  exp_t       exp_q[$];
  int         out_cycles[$];
  int         checks   = 0;
  int         failures = 0;
  int         cyc_cnt  = 0;
  logic       stall_prev = 1'b0;
  logic [W:0] prev_sum = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] ex);
    checks++;
    if (act !== ex) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, ex);
    end
  endtask

  // Reference: exact integer arithmetic on the operands.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    exp_t   e;
    longint sx, sy, r, maxv, minv;
    sx   = $signed(x);
    sy   = $signed(y);
    r    = s ? sx - sy : sx + sy;
    maxv = (longint'(1) <<< (W-1)) - 1;
    minv = -(longint'(1) <<< (W-1));
    if (s) begin
      e.s[W-1:0] = x - y;
      e.s[W]     = (x < y);
    end else begin
      e.s = {1'b0, x} + {1'b0, y};
    end
    e.o  = (r > maxv) || (r < minv);
    e.sb = s;
    return e;
  endfunction

  function automatic logic [W-1:0] pick();
    logic [W-1:0] v;
    case ($urandom % 6)
      0: v = '0;
      1: v = '1;
      2: v = 32'h8000_0000;
      3: v = 32'h7FFF_FFFF;
      4: v = 32'h0000_0001;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Scoreboard: handshake rule, output stability under stall, in-order results.
  always @(negedge clk) begin
    if (rst) begin
      chk("in_ready_in_rst", in_ready, 0);
      exp_q.delete();
      stall_prev <= 1'b0;
    end else begin
      chk("in_ready_rule", in_ready, !(out_valid && !out_ready));
      if (stall_prev) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_sum", sum, prev_sum);
      end
      if (out_valid && out_ready) begin
        out_cycles.push_back(cyc_cnt);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output actual sum=%h required no output", sum);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("sb_sum", sum, e.s);
          chk("sb_overflow", overflow, e.o);
          chk("sb_sub_o", sub_o, e.sb);
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, sub));
      stall_prev <= out_valid && !out_ready;
      prev_sum   <= sum;
    end
  end

  task automatic run_one(input string nm, input logic [W-1:0] xa, input logic [W-1:0] xb,
                         input logic xs, input logic [W:0] es, input logic eo);
    int lat;
    a = xa; b = xb; sub = xs; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, "_latency"}, lat, S);
    chk({nm, "_sum"}, sum, es);
    chk({nm, "_overflow"}, overflow, eo);
    chk({nm, "_sub_o"}, sub_o, xs);
    @(posedge clk); #1;
  endtask

  initial begin
    int n, c0, accepted, iters;
    logic took;

    // Reset with in_valid held high
    rst = 1'b1; in_valid = 1'b1; a = $urandom; b = $urandom; sub = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_sub_o", sub_o, 0);
    rst = 1'b0; in_valid = 1'b0;
    n = 0;
    repeat (8) begin @(posedge clk); #1; if (out_valid) n++; end
    chk("post_rst_quiet", n, 0);

    // Boundary values
    run_one("wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 33'h1_0000_0000, 1'b0);
    run_one("zero_minus_one", 32'h0000_0000, 32'h0000_0001, 1'b1, 33'h1_FFFF_FFFF, 1'b0);
    run_one("min_minus_one", 32'h8000_0000, 32'h0000_0001, 1'b1, 33'h0_7FFF_FFFF, 1'b1);

    // Streaming 16 back-to-back ops
    out_cycles.delete();
    c0 = cyc_cnt;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      a = $urandom; b = $urandom; sub = 1'($urandom % 2); in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (S + 2) begin @(posedge clk); #1; end
    chk("stream_count", out_cycles.size(), 16);
    if (out_cycles.size() == 16) begin
      chk("stream_first_cycle", out_cycles[0], c0 + S);
      chk("stream_last_cycle", out_cycles[15], c0 + S + 15);
    end

    // Random back-pressure, 1000 ops
    accepted = 0; iters = 0;
    a = pick(); b = pick(); sub = 1'($urandom % 2);
    while (accepted < 1000 && iters < 20000) begin
      in_valid  = 1'b1;
      out_ready = 1'($urandom % 2);
      #1;
      took = in_ready;
      @(posedge clk); #1;
      if (took) begin
        accepted++;
        a = pick(); b = pick(); sub = 1'($urandom % 2);
      end
      iters++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (S + 2) begin @(posedge clk); #1; end
    chk("bp_accepted", accepted, 1000);
    chk("bp_drained", exp_q.size(), 0);

    // Reset with 3 ops in flight
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = $urandom; b = $urandom; sub = 1'($urandom % 2); in_valid = 1'b1;
      @(posedge clk); #1;
    end
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    n = 0;
    repeat (8) begin @(posedge clk); #1; if (out_valid) n++; end
    chk("flush_quiet", n, 0);
    run_one("after_flush", 32'h1234_5678, 32'h1111_1111, 1'b0, 33'h0_2345_6789, 1'b0);

    chk("final_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
